// File: rtl/iir_biquad_mc.sv
// Time-multiplexed multi-channel fixed-point biquad section.
// One shared multiplier; per-channel w[n-1]/w[n-2] delay state.
module iir_biquad_mc #(
    parameter  int FRAC_BITS = 16,
    parameter  int INT_BITS  = 22,
    parameter  int CHANNELS  = 4,
    parameter  int CH_W      = 2,
    localparam int W         = 1 + INT_BITS + FRAC_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_data,
    input  logic [CH_W-1:0]     in_channel,
    input  logic signed [W-1:0] coef_a,
    input  logic signed [W-1:0] coef_b,
    input  logic signed [W-1:0] coef_c,
    input  logic signed [W-1:0] coef_d,
    input  logic                clear,
    output logic                out_valid,
    output logic signed [W-1:0] out_data,
    output logic [CH_W-1:0]     out_channel,
    output logic                out_sat,
    output logic                err_chan
);
    localparam int AW = W + 3;
    localparam int PW = 2 * W;
    localparam int NS = 2 ** CH_W;
    localparam logic [CH_W:0] NCH = (CH_W + 1)'(CHANNELS);

    typedef enum logic [2:0] {IDLE, MA, MB, MC, MD, DONE} state_t;

    state_t               state;
    logic signed [W-1:0]  x_r, a_r, b_r, c_r, d_r, w_r;
    logic [CH_W-1:0]      ch_r;
    logic signed [AW-1:0] acc;
    logic signed [W-1:0]  w1 [NS];
    logic signed [W-1:0]  w2 [NS];

    logic signed [W-1:0]  mul_a, mul_b;
    logic signed [PW-1:0] prod, shifted;
    logic signed [AW-1:0] term, ysum;
    logic [W:0]           ws, ys;
    logic                 bad;

    // Each scaled product is clamped to +/-2^W so three terms never wrap the accumulator.
    function automatic logic signed [AW-1:0] clamp_term(input logic signed [PW-1:0] v);
        if (v[PW-1:W] == {W{v[W]}})
            return {{2{v[W]}}, v[W:0]};
        else if (v[PW-1])
            return {3'b111, {W{1'b0}}};
        else
            return {3'b000, {W{1'b1}}};
    endfunction

    // Returns {clamped, value}.
    function automatic logic [W:0] sat_w(input logic signed [AW-1:0] v);
        if (v[AW-1:W-1] == {(AW-W+1){v[W-1]}})
            return {1'b0, v[W-1:0]};
        else if (v[AW-1])
            return {2'b11, {(W-1){1'b0}}};
        else
            return {2'b10, {(W-1){1'b1}}};
    endfunction

    always_comb begin
        mul_a = a_r;
        mul_b = x_r;
        case (state)
            MB:      begin mul_a = b_r; mul_b = w1[ch_r]; end
            MC:      begin mul_a = c_r; mul_b = w2[ch_r]; end
            MD:      begin mul_a = d_r; mul_b = w1[ch_r]; end
            default: begin mul_a = a_r; mul_b = x_r; end
        endcase
    end

    assign prod    = PW'(mul_a) * PW'(mul_b);
    assign shifted = prod >>> FRAC_BITS;
    assign term    = clamp_term(shifted);
    assign ws      = sat_w(acc);
    assign ysum    = {{3{ws[W-1]}}, ws[W-1:0]} + term
                   + {{3{w2[ch_r][W-1]}}, w2[ch_r]};
    assign ys      = sat_w(ysum);
    assign bad     = {1'b0, in_channel} >= NCH;
    assign in_ready = rst_n && (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            x_r         <= '0;
            a_r         <= '0;
            b_r         <= '0;
            c_r         <= '0;
            d_r         <= '0;
            w_r         <= '0;
            ch_r        <= '0;
            acc         <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
            out_sat     <= 1'b0;
            err_chan    <= 1'b0;
            for (int i = 0; i < NS; i++) begin
                w1[i] <= '0;
                w2[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            err_chan  <= 1'b0;
            if (clear) begin
                for (int i = 0; i < NS; i++) begin
                    w1[i] <= '0;
                    w2[i] <= '0;
                end
            end
            if (clear && state != IDLE) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (in_valid) begin
                        x_r  <= in_data;
                        a_r  <= coef_a;
                        b_r  <= coef_b;
                        c_r  <= coef_c;
                        d_r  <= coef_d;
                        ch_r <= in_channel;
                        if (bad) err_chan <= 1'b1;
                        else     state    <= MA;
                    end
                    MA: begin
                        acc   <= term;
                        state <= MB;
                    end
                    MB: begin
                        acc   <= acc - term;
                        state <= MC;
                    end
                    MC: begin
                        acc   <= acc - term;
                        state <= MD;
                    end
                    // Result registered here so out_valid is high during DONE.
                    MD: begin
                        w_r         <= ws[W-1:0];
                        out_data    <= ys[W-1:0];
                        out_sat     <= ws[W] | ys[W];
                        out_channel <= ch_r;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                    DONE: begin
                        w2[ch_r] <= w1[ch_r];
                        w1[ch_r] <= w_r;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_iir_biquad_mc.sv
// Randomised bench for iir_biquad_mc against an arithmetic reference model.
module tb_iir_biquad_mc;
    localparam int FB  = 16;
    localparam int W   = 39;
    localparam int NCH = 3;
    localparam int CW  = 3;
    localparam longint TMAX = (64'sd1 <<< W) - 1;
    localparam longint TMIN = -(64'sd1 <<< W);
    localparam longint SMAX = (64'sd1 <<< (W - 1)) - 1;
    localparam longint SMIN = -(64'sd1 <<< (W - 1));

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_data;
    logic [CW-1:0]       in_channel;
    logic signed [W-1:0] coef_a, coef_b, coef_c, coef_d;
    logic                clear;
    logic                out_valid;
    logic signed [W-1:0] out_data;
    logic [CW-1:0]       out_channel;
    logic                out_sat;
    logic                err_chan;

    int checks = 0;
    int failures = 0;
    longint mw1 [8];
    longint mw2 [8];
    bit hit;

    iir_biquad_mc #(
        .FRAC_BITS(FB), .INT_BITS(22), .CHANNELS(NCH), .CH_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_channel(in_channel),
        .coef_a(coef_a), .coef_b(coef_b),
        .coef_c(coef_c), .coef_d(coef_d),
        .clear(clear),
        .out_valid(out_valid), .out_data(out_data),
        .out_channel(out_channel), .out_sat(out_sat),
        .err_chan(err_chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // floor(p*q / 2^FB), clamped to the accumulator term range
    function automatic longint mterm(input longint p, input longint q);
        logic signed [127:0] pr;
        pr = 128'(p) * 128'(q);
        pr = pr >>> FB;
        if (pr > 128'(TMAX)) return TMAX;
        if (pr < 128'(TMIN)) return TMIN;
        return longint'(pr);
    endfunction

    function automatic longint msat(input longint v);
        if (v > SMAX) begin hit = 1'b1; return SMAX; end
        if (v < SMIN) begin hit = 1'b1; return SMIN; end
        return v;
    endfunction

    task automatic zero_model();
        for (int i = 0; i < 8; i++) begin
            mw1[i] = 0;
            mw2[i] = 0;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic do_sample(input int ch, input longint x, input longint a,
                             input longint b, input longint c, input longint d,
                             input bit clr);
        longint w, t, y;
        bit s;
        wait_ready();
        in_valid   = 1'b1;
        in_channel = CW'(ch);
        in_data    = W'(x);
        coef_a = W'(a); coef_b = W'(b); coef_c = W'(c); coef_d = W'(d);
        clear = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        coef_a = W'($urandom); coef_b = W'($urandom);
        in_data = W'($urandom);
        if (clr) zero_model();
        hit = 1'b0;
        w = msat(mterm(a, x) - mterm(b, mw1[ch]) - mterm(c, mw2[ch]));
        t = mterm(d, mw1[ch]);
        y = msat(w + t + mw2[ch]);
        s = hit;
        mw2[ch] = mw1[ch];
        mw1[ch] = w;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check("ov_early", longint'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        check("ov", longint'(out_valid), 1);
        check("y", longint'(out_data), y);
        check("och", longint'(out_channel), longint'(ch));
        check("osat", longint'(out_sat), longint'(s));
    endtask

    task automatic quiet_cycles(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check(tag, longint'(out_valid), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_data = 39'sd12345;
        in_channel = '0; clear = 1'b0;
        coef_a = 39'sd65536; coef_b = '0; coef_c = '0; coef_d = '0;
        zero_model();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("rst_ov", longint'(out_valid), 0);
            check("rst_od", longint'(out_data), 0);
            check("rst_rdy", longint'(in_ready), 0);
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rdy_after_rst", longint'(in_ready), 1);
        check("err_after_rst", longint'(err_chan), 0);

        // impulse on ch0
        do_sample(0, 65536, 65536, 0, 0, 0, 0);
        do_sample(0, 0, 65536, 0, 0, 0, 0);
        do_sample(0, 0, 65536, 0, 0, 0, 0);
        do_sample(0, 0, 65536, 0, 0, 0, 0);
        // feedback, b = -0.5
        do_sample(0, 65536, 65536, -32768, 0, 0, 0);
        do_sample(0, 0, 65536, -32768, 0, 0, 0);

        // channel isolation from zeroed state
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        zero_model();
        do_sample(1, 131072, 65536, 0, 0, 0, 0);
        do_sample(0, 0, 65536, 0, 0, 0, 0);
        do_sample(1, 0, 65536, 0, 0, 0, 0);

        // saturation both ways
        do_sample(2, SMAX, SMAX, 0, 0, 0, 0);
        do_sample(2, SMAX, SMIN, 0, 0, 0, 0);

        // invalid channel
        wait_ready();
        in_valid = 1'b1; in_channel = 3'd7; in_data = 39'sd65536;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("err_pulse", longint'(err_chan), 1);
        check("err_rdy", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        check("err_drop", longint'(err_chan), 0);
        quiet_cycles("err_noov", 6);

        // clear while busy
        wait_ready();
        in_valid = 1'b1; in_channel = 3'd1; in_data = 39'sd65536;
        coef_a = 39'sd65536;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        check("clr_rdy", longint'(in_ready), 1);
        check("clr_noov", longint'(out_valid), 0);
        @(negedge clk);
        clear = 1'b0;
        zero_model();
        quiet_cycles("clr_quiet", 6);
        do_sample(1, 65536, 65536, 0, 0, 0, 0);
        do_sample(1, 0, 65536, 0, 0, 0, 0);
        do_sample(1, 0, 65536, 0, 0, 0, 0);

        // randomised traffic, occasional clear-with-accept and extremes
        for (int i = 0; i < 48; i++) begin
            int ch;
            longint x, a, b, c, d;
            ch = int'($urandom_range(0, NCH - 1));
            x  = longint'($urandom_range(0, 2_000_000)) - 1_000_000;
            a  = longint'($urandom_range(0, 262_144)) - 131_072;
            b  = longint'($urandom_range(0, 65_536)) - 32_768;
            c  = longint'($urandom_range(0, 32_768)) - 16_384;
            d  = longint'($urandom_range(0, 262_144)) - 131_072;
            if ($urandom_range(0, 7) == 0) x = ($urandom_range(0, 1) != 0) ? SMAX : SMIN;
            do_sample(ch, x, a, b, c, d, $urandom_range(0, 9) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/iir_biquad_mc.md
Name: iir_biquad_mc

Overview:
- Parametrised, time-multiplexed multi-channel successor of the fixed-point lowpass biquad section.
- Computes per channel: w[n] = a*x[n] - b*w[n-1] - c*w[n-2]; y[n] = w[n] + d*w[n-1] + w[n-2].
- Uses one shared multiplier under a 6-state FSM, keeps per-channel delay state in registers, and adds valid/ready input handshake, saturation, and state clear.
- Sits in the filter datapath between the sample source and the downstream IEEE-754 conversion stage.

Parameters:
- FRAC_BITS, 16, fractional bits of every data/coef word.
- INT_BITS, 22, integer bits (excluding sign).
- CHANNELS, 4, independent filter channels (>=1).
- CH_W, 2, width of channel index; must be >= clog2(CHANNELS), min 1.
- Derived W = 1+INT_BITS+FRAC_BITS: signed two's-complement word width (default 39).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  W  signed sample x.
- in_channel  in  CH_W  channel of sample.
- coef_a, coef_b, coef_c, coef_d  in  W each  signed coefficients; sampled only on the accept edge.
- clear  in  1  zero all channel state.
- out_valid  out  1  one-cycle pulse, result valid.
- out_data  out  W  signed y.
- out_channel  out  CH_W  channel of out_data.
- out_sat  out  1  saturation occurred in this result (w or y); qualified by out_valid.
- err_chan  out  1  one-cycle pulse: accepted sample had in_channel >= CHANNELS.

Behaviour:
- Reset (rst_n=0 at edge): FSM=IDLE; all w1/w2 per channel = 0; in_ready=1 after the reset edge; out_valid=0, out_data=0, out_channel=0, out_sat=0, err_chan=0. Reset overrides clear and in_valid.
- Accept = in_valid & in_ready at a rising edge. x, channel and all four coefs are latched on that edge.
- FSM states: IDLE -> MA -> MB -> MC -> MD -> DONE -> IDLE. Each non-IDLE state lasts exactly one cycle. in_ready=1 only in IDLE.
  - MA: acc = a*x.
  - MB: acc -= b*w1.
  - MC: acc -= c*w2.
  - MD: w = sat(acc) stored; t = d*w1.
  - DONE: y = sat(w + t + w2); write w2<=w1, w1<=w for that channel; drive out_data, out_channel, out_sat; out_valid=1 for this one cycle.
- Latency: out_valid is high in the 5th cycle after the accept edge. Max throughput: 1 sample per 6 cycles per block (accept possible the cycle after DONE).
- Product rule: full 2W-bit product, arithmetic shift right by FRAC_BITS (truncate toward -inf).
- Accumulator: W+3 bits, no internal wrap.
- sat(): clamp to [-2^(W-1), 2^(W-1)-1]. out_sat=1 if either the w clamp or the y clamp activated. The stored w is the saturated value.
- Invalid channel (in_channel >= CHANNELS): sample accepted; err_chan pulses the cycle after accept; FSM stays IDLE; no state write; no out_valid.
- clear in IDLE: all w1/w2 <= 0 on that edge; a simultaneous accept is honoured, and its computation uses zero state.
- clear while busy (MA..DONE): computation aborted; no out_valid; all state zeroed; FSM -> IDLE, so in_ready=1 the next cycle.
- Outputs out_data/out_channel/out_sat hold their last values between pulses. out_valid has no backpressure: the consumer must accept it.
- Coefficient changes while busy do not affect the in-flight sample.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=0 during reset; in_ready=1 the first cycle after release.
- Impulse on ch0 with a=65536 (1.0), b=c=d=0: x=65536, 0, 0, 0 -> y=65536, 0, 65536, 0; each out_valid 5 cycles after its accept; out_channel=0; out_sat=0.
- Feedback on ch0 with a=65536, b=-32768 (-0.5), c=0, d=0: x=65536 then 0 -> w=65536, then 32768; y=65536, then 32768.
- Channel isolation: ch1 x=131072, then ch0 x=0, then ch1 x=0 -> y=131072, 0, 0. ch1 w1=131072 is untouched by the ch0 sample and the last result carries out_channel=1.
- Saturation: a=x=2^38-1, others 0 -> out_data=2^38-1, out_sat=1. Then a=-2^38, x=2^38-1 -> out_data=-2^38, out_sat=1.
- Clear mid-op: accept at cycle 0, clear=1 at cycle 2 -> no out_valid; in_ready=1 at cycle 3; next impulse behaves as from reset. Also in_channel=7 -> err_chan one pulse, no out_valid.
